rv32i_decoder: RTL and testbench

- Registered RV32I instruction decoder in the single-issue core, between the fetch stage and the register file / load-store logic.
- Splits a 32-bit instruction into opcode, funct fields, register indices and a sign-extended immediate.
- Flags whether the instruction is a legal RV32I encoding; the core halts on an invalid instruction.

---
 rtl/rv32i_pkg.sv | 29 ++
 rtl/rv32i_imm_gen.sv | 27 ++
 rtl/rv32i_decoder.sv | 152 +++++++++++++++
 tb/tb_rv32i_decoder.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I decoder: base opcodes and the
// immediate-format selector used between the decoder and immediate generator.
package rv32i_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   // FMT_R doubles as "no immediate": the generator returns zero for it.
   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } imm_fmt_e;

endpackage

// File: rtl/rv32i_imm_gen.sv
// Combinational immediate generator: assembles and sign-extends the
// immediate for the given instruction format. Only instr[31:7] carries
// immediate bits, so the opcode field is not an input.
module rv32i_imm_gen
   import rv32i_pkg::*;
(
   input  logic [31:7]     instr_i,
   input  imm_fmt_e        fmt_i,
   output logic [XLEN-1:0] imm_o
);

   // Select and sign-extend the immediate according to the format.
   always_comb begin
      imm_o = '0;
      unique case (fmt_i)
         FMT_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
         FMT_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         FMT_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                         instr_i[30:25], instr_i[11:8], 1'b0};
         FMT_U: imm_o = {instr_i[31:12], 12'b0};
         FMT_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                         instr_i[20], instr_i[30:21], 1'b0};
         default: imm_o = '0;
      endcase
   end

endmodule

// File: rtl/rv32i_decoder.sv
// Registered RV32I instruction decoder (one-cycle latency).
// Fields are raw bit slices; o_imm is format-dependent; o_valid flags a legal
// RV32I encoding. Define RV32I_DECODER_STRICT_EN to fold funct-field checks
// into o_valid; without it, legality depends only on opcode, instr[1:0] and
// the word being nonzero.
// Stage control: clk_en is a plain stage enable (no handshake). When low, all
// outputs hold; rst wins over clk_en and clears everything including o_valid.
module rv32i_decoder
   import rv32i_pkg::*;
#(
   parameter int XLEN_P = 32
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              clk_en,
   input  logic [XLEN_P-1:0] i_instruction,
   output logic [6:0]        o_opcode,
   output logic [6:0]        o_funct7,
   output logic [2:0]        o_funct3,
   output logic [4:0]        o_rs1,
   output logic [4:0]        o_rs2,
   output logic [4:0]        o_rd,
   output logic [XLEN_P-1:0] o_imm,
   output logic              o_valid
);

   logic [6:0] opcode;
   logic [6:0] funct7;
   logic [2:0] funct3;
   imm_fmt_e   fmt;
   logic       opc_known;
   logic       funct_ok;
   logic [XLEN-1:0] imm;

   logic [6:0]      opcode_q, opcode_d;
   logic [6:0]      funct7_q, funct7_d;
   logic [2:0]      funct3_q, funct3_d;
   logic [4:0]      rs1_q,    rs1_d;
   logic [4:0]      rs2_q,    rs2_d;
   logic [4:0]      rd_q,     rd_d;
   logic [XLEN-1:0] imm_q,    imm_d;
   logic            valid_q,  valid_d;

   assign opcode = i_instruction[6:0];
   assign funct7 = i_instruction[31:25];
   assign funct3 = i_instruction[14:12];

   // Map the opcode to its immediate format and note whether it is a base opcode.
   always_comb begin
      fmt       = FMT_R;
      opc_known = 1'b1;
      case (opcode)
         OPC_LOAD, OPC_OP_IMM, OPC_JALR,
         OPC_SYSTEM, OPC_MISC_MEM: fmt = FMT_I;
         OPC_STORE:                fmt = FMT_S;
         OPC_BRANCH:               fmt = FMT_B;
         OPC_LUI, OPC_AUIPC:       fmt = FMT_U;
         OPC_JAL:                  fmt = FMT_J;
         OPC_OP:                   fmt = FMT_R;
         default: begin
            fmt       = FMT_R;
            opc_known = 1'b0;
         end
      endcase
   end

`ifdef RV32I_DECODER_STRICT_EN
   // Reject funct encodings that are reserved within an otherwise known opcode.
   always_comb begin
      funct_ok = 1'b1;
      case (opcode)
         OPC_JALR:   funct_ok = (funct3 == 3'b000);
         OPC_BRANCH: funct_ok = (funct3 != 3'b010) && (funct3 != 3'b011);
         OPC_LOAD:   funct_ok = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                                (funct3 == 3'b010) || (funct3 == 3'b100) ||
                                (funct3 == 3'b101);
         OPC_STORE:  funct_ok = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                                (funct3 == 3'b010);
         OPC_OP_IMM: begin
            if (funct3 == 3'b001)
               funct_ok = (funct7 == 7'b0000000);
            else if (funct3 == 3'b101)
               funct_ok = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            else
               funct_ok = 1'b1;
         end
         OPC_OP:     funct_ok = (funct7 == 7'b0000000) ||
                                ((funct7 == 7'b0100000) &&
                                 ((funct3 == 3'b000) || (funct3 == 3'b101)));
         // Only ECALL and EBREAK exist in base RV32I SYSTEM space.
         OPC_SYSTEM: funct_ok = (i_instruction == 32'h0000_0073) ||
                                (i_instruction == 32'h0010_0073);
         default:    funct_ok = 1'b1;
      endcase
   end
`else
   assign funct_ok = 1'b1;
`endif

   rv32i_imm_gen u_imm_gen (
      .instr_i (i_instruction[31:7]),
      .fmt_i   (fmt),
      .imm_o   (imm)
   );

   // Next-state for the output registers: the decode of the current word.
   always_comb begin
      opcode_d = opcode;
      funct7_d = funct7;
      funct3_d = funct3;
      rs1_d    = i_instruction[19:15];
      rs2_d    = i_instruction[24:20];
      rd_d     = i_instruction[11:7];
      imm_d    = imm;
      // opc_known already implies instr[1:0]==11; checked explicitly for clarity.
      valid_d  = (i_instruction[1:0] == 2'b11) && opc_known &&
                 (i_instruction != '0) && funct_ok;
   end

   // Output registers: synchronous clear, update only on stage enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         opcode_q <= '0;
         funct7_q <= '0;
         funct3_q <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         rd_q     <= '0;
         imm_q    <= '0;
         valid_q  <= 1'b0;
      end else if (clk_en) begin
         opcode_q <= opcode_d;
         funct7_q <= funct7_d;
         funct3_q <= funct3_d;
         rs1_q    <= rs1_d;
         rs2_q    <= rs2_d;
         rd_q     <= rd_d;
         imm_q    <= imm_d;
         valid_q  <= valid_d;
      end
   end

   assign o_opcode = opcode_q;
   assign o_funct7 = funct7_q;
   assign o_funct3 = funct3_q;
   assign o_rs1    = rs1_q;
   assign o_rs2    = rs2_q;
   assign o_rd     = rd_q;
   assign o_imm    = imm_q;
   assign o_valid  = valid_q;

endmodule

// File: tb/tb_rv32i_decoder.sv
// Self-checking bench for rv32i_decoder: a table of hand-decoded instruction
// words plus directed reset and clock-enable hold sequences.
module tb_rv32i_decoder;

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic [6:0]  opc;
      logic [6:0]  f7;
      logic [2:0]  f3;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic        valid;
   } vec_t;

`ifdef RV32I_DECODER_STRICT_EN
   localparam logic STRICT = 1'b1;
`else
   localparam logic STRICT = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        clk_en;
   logic [31:0] i_instruction;
   logic [6:0]  o_opcode;
   logic [6:0]  o_funct7;
   logic [2:0]  o_funct3;
   logic [4:0]  o_rs1;
   logic [4:0]  o_rs2;
   logic [4:0]  o_rd;
   logic [31:0] o_imm;
   logic        o_valid;

   int checks = 0;
   int errors = 0;
   vec_t vq[$];

   rv32i_decoder dut (
      .clk           (clk),
      .rst           (rst),
      .clk_en        (clk_en),
      .i_instruction (i_instruction),
      .o_opcode      (o_opcode),
      .o_funct7      (o_funct7),
      .o_funct3      (o_funct3),
      .o_rs1         (o_rs1),
      .o_rs2         (o_rs2),
      .o_rd          (o_rd),
      .o_imm         (o_imm),
      .o_valid       (o_valid)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one active edge and settle before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add_vec(input string name, input logic [31:0] instr,
                          input logic [6:0] opc, input logic [6:0] f7,
                          input logic [2:0] f3, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] imm, input logic valid);
      vec_t v;
      v.name = name; v.instr = instr; v.opc = opc; v.f7 = f7; v.f3 = f3;
      v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.imm = imm; v.valid = valid;
      vq.push_back(v);
   endtask

   // Scoreboard compare of every output against an expected record.
   task automatic check(input vec_t e);
      logic [64:0] act, exp;
      act = {o_opcode, o_funct7, o_funct3, o_rs1, o_rs2, o_rd, o_imm, o_valid};
      exp = {e.opc, e.f7, e.f3, e.rs1, e.rs2, e.rd, e.imm, e.valid};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got opc=%b f7=%b f3=%b rs1=%0d rs2=%0d rd=%0d imm=%h valid=%b, expected opc=%b f7=%b f3=%b rs1=%0d rs2=%0d rd=%0d imm=%h valid=%b",
                  e.name, o_opcode, o_funct7, o_funct3, o_rs1, o_rs2, o_rd, o_imm, o_valid,
                  e.opc, e.f7, e.f3, e.rs1, e.rs2, e.rd, e.imm, e.valid);
      end
   endtask

   initial begin
      vec_t zero_v, addi_v;

      //        name        instr         opc        f7         f3     rs1 rs2 rd  imm           valid
      add_vec("addi5",    32'h0050_0093, 7'b0010011, 7'h00, 3'b000, 0,  5,  1, 32'h0000_0005, 1'b1);
      add_vec("sw_m4",    32'hFE20_AE23, 7'b0100011, 7'h7F, 3'b010, 1,  2, 28, 32'hFFFF_FFFC, 1'b1);
      add_vec("beq_m4",   32'hFE20_8EE3, 7'b1100011, 7'h7F, 3'b000, 1,  2, 29, 32'hFFFF_FFFC, 1'b1);
      add_vec("lui",      32'h1234_52B7, 7'b0110111, 7'h09, 3'b101, 8,  3,  5, 32'h1234_5000, 1'b1);
      add_vec("jal8",     32'h0080_00EF, 7'b1101111, 7'h00, 3'b000, 0,  8,  1, 32'h0000_0008, 1'b1);
      add_vec("all_zero", 32'h0000_0000, 7'b0000000, 7'h00, 3'b000, 0,  0,  0, 32'h0000_0000, 1'b0);
      add_vec("all_ones", 32'hFFFF_FFFF, 7'b1111111, 7'h7F, 3'b111, 31, 31, 31, 32'h0000_0000, 1'b0);
      add_vec("unk_opc",  32'h0000_007F, 7'b1111111, 7'h00, 3'b000, 0,  0,  0, 32'h0000_0000, 1'b0);
      add_vec("low_bits", 32'h0050_0090, 7'b0010000, 7'h00, 3'b000, 0,  5,  1, 32'h0000_0000, 1'b0);
      add_vec("sll_f7",   32'h4000_1033, 7'b0110011, 7'h20, 3'b001, 0,  0,  0, 32'h0000_0000, !STRICT);
      add_vec("sub",      32'h4000_0033, 7'b0110011, 7'h20, 3'b000, 0,  0,  0, 32'h0000_0000, 1'b1);
      add_vec("ecall",    32'h0000_0073, 7'b1110011, 7'h00, 3'b000, 0,  0,  0, 32'h0000_0000, 1'b1);
      add_vec("ebreak",   32'h0010_0073, 7'b1110011, 7'h00, 3'b000, 0,  1,  0, 32'h0000_0001, 1'b1);
      add_vec("addi_m1",  32'hFFF0_0093, 7'b0010011, 7'h7F, 3'b000, 0, 31,  1, 32'hFFFF_FFFF, 1'b1);
      add_vec("jalr",     32'h0000_8067, 7'b1100111, 7'h00, 3'b000, 1,  0,  0, 32'h0000_0000, 1'b1);
      add_vec("fence",    32'h0000_000F, 7'b0001111, 7'h00, 3'b000, 0,  0,  0, 32'h0000_0000, 1'b1);
      add_vec("lw",       32'h0000_2003, 7'b0000011, 7'h00, 3'b010, 0,  0,  0, 32'h0000_0000, 1'b1);
      add_vec("auipc",    32'hFFFF_F017, 7'b0010111, 7'h7F, 3'b111, 31, 31,  0, 32'hFFFF_F000, 1'b1);

      zero_v = '{name: "reset", instr: 32'h0, opc: 7'h0, f7: 7'h0, f3: 3'h0,
                 rs1: 5'h0, rs2: 5'h0, rd: 5'h0, imm: 32'h0, valid: 1'b0};
      addi_v = vq[0];

      // Reset for two edges with a nonzero word on the input.
      rst = 1'b1;
      clk_en = 1'b1;
      i_instruction = 32'h0050_0093;
      step();
      step();
      check(zero_v);

      // Table-driven decode, one vector per cycle.
      rst = 1'b0;
      foreach (vq[i]) begin
         i_instruction = vq[i].instr;
         step();
         check(vq[i]);
      end

      // Enable/hold: decode addi, then hold it while a store is presented.
      i_instruction = 32'h0050_0093;
      clk_en = 1'b1;
      step();
      check(addi_v);
      clk_en = 1'b0;
      i_instruction = 32'hFE20_AE23;
      for (int c = 0; c < 3; c++) begin
         addi_v.name = $sformatf("hold%0d", c);
         step();
         check(addi_v);
      end

      // Reset takes priority over a deasserted enable.
      rst = 1'b1;
      step();
      zero_v.name = "rst_no_en";
      check(zero_v);

      // Enable still low after reset: outputs stay cleared.
      rst = 1'b0;
      step();
      zero_v.name = "idle_after_rst";
      check(zero_v);

      // Re-enable picks up the presented store.
      clk_en = 1'b1;
      step();
      check(vq[1]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
